mips_ifu: RTL and testbench
===========================

# mips_ifu

Instruction fetch unit for the single-cycle MIPS core; the upstream end of the opcode/control interface. It holds the PC, fetches words from instruction memory over a request/acknowledge handshake, and presents the instruction and its `op` field to the main control decoder and datapath. It then takes back the decoder's `Branch`/`Jump` outputs and the ALU `zero` flag to select the next PC. It also counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; always equals `pc`, bits [1:0] = 0.
- `imem_ack`  in  1: read data valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32: instruction word, sampled when `imem_req & imem_ack`.
- `ins_valid`  out  1: `ins`/`op` hold a fetched, unconsumed instruction.
- `ins_ready`  in  1: datapath consumes the instruction this cycle.
- `ins`  out  32: instruction register.
- `op`  out  6: `ins[31:26]`, feeds the control decoder.
- `pc`  out  32: address of the instruction in `ins`.
- `Branch`  in  1: from the decoder, valid while `ins_valid`.
- `Jump`  in  1: from the decoder, valid while `ins_valid`.
- `zero`  in  1: ALU equality flag for the current instruction.
- `retired`  out  32: count of consumed instructions.

## Operation
- FSM states: FETCH, HOLD.
  - FETCH: `imem_req`=1, `ins_valid`=0. On `imem_ack`: `ins`←`imem_rdata`, go to HOLD.
  - HOLD: `imem_req`=0, `ins_valid`=1. On `ins_ready` (accept): `pc`←`npc`, `retired`←`retired`+1, go to FETCH.
- `npc` priority, evaluated only at accept:
  - `Jump`=1: {`pc`+4 [31:28], `ins[25:0]`, 2'b00}.
  - else `Branch & zero`: `pc` + 4 + (sign-extended `ins[15:0]` << 2).
  - else `pc` + 4.
- All PC arithmetic is modulo 2^32; wrap-around is silent.
- `Branch` with `zero`=0 falls through to `pc`+4.
- `Jump` and `Branch` both high: `Jump` wins.
- `ins_ready` outside HOLD is ignored. `imem_ack` outside FETCH is ignored.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- Reset values:
  - state = FETCH, `pc` = `RESET_PC`, `ins` = 0, `retired` = 0.
  - Therefore `imem_req`=1 and `ins_valid`=0 in the first cycle after `rst` falls.
- Reset in HOLD discards the held instruction; `ins_valid`=0 from the next cycle.
- Reset in FETCH abandons the outstanding request; a late `imem_ack` in the cycle after reset completes the fresh fetch of `RESET_PC`.

## Timing
- `imem_req`, `ins_valid` and `imem_addr` are decoded from registered state only. There is no combinational path from any input to any output.
- Zero-wait memory (`imem_ack` the same cycle as `imem_req`): `ins_valid` rises the next cycle.
- Sustained throughput with zero-wait memory and `ins_ready` held high: one instruction per 2 cycles.
- On accept, the new `pc`/`imem_addr` appears the next cycle, and `retired` updates in that same cycle.
- `ins` is stable for the whole HOLD state, so decoder outputs stay constant until accept.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants: OP_RTYPE 6'b000000, OP_ORI 6'b001101, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010.
  - Default `RESET_PC`.
  - The FSM state encoding.
- One sub-module `mips_npc`: combinational next-PC select (inputs `pc`, `ins`, `Branch`, `Jump`, `zero`; output `npc`). It is shared later with the datapath.

## Test plan
- Reset, then zero-wait memory returning 32'h3401_0005 (ori) with `ins_ready`=1:
  - `imem_addr`=32'h0000_3000 in cycle 1.
  - `ins_valid`, `op`=6'b001101 in cycle 2.
  - `pc`=32'h0000_3004 and `retired`=1 in cycle 3.
- beq 32'h1000_FFFF with `Branch`=1:
  - `zero`=1 at `pc`=32'h3010: next `pc`=32'h3010.
  - `zero`=0: next `pc`=32'h3014.
- j 32'h0800_0C40 at `pc`=32'h3020: next `pc`=32'h0000_3100. Repeat with `Branch`=1, `zero`=1 also asserted: result is still 32'h0000_3100.
- Backpressure and memory stall:
  - Hold `ins_ready`=0 for 5 cycles: `ins`, `op`, `pc` stay constant; `retired` is unchanged.
  - `imem_ack` delayed 3 cycles: `imem_req` stays high and `imem_addr` stays constant throughout.
- Wrap cases:
  - `pc`=32'hFFFF_FFFC with no branch or jump: next `pc`=0.
  - `retired` preset to 32'hFFFF_FFFF by forcing: rolls to 0 on the next accept.
- Assert `rst` during HOLD: next cycle `ins_valid`=0, `pc`=`RESET_PC`, `retired`=0, `imem_req`=1. A stray `ins_ready` in that cycle changes nothing.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, the fetch unit's default reset
// vector and the fetch FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } ifuState_t;

endpackage

// File: rtl/mips_npc.sv
// Combinational next-PC select, shared between the fetch unit and the datapath.
module mips_npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] npc
);

  logic [31:0] pcPlus4_s;
  logic [31:0] brOffset_s;
  logic [31:0] jumpTarget_s;
  logic        unusedOp_s;

  assign pcPlus4_s    = pc + 32'd4;
  assign brOffset_s   = {{14{ins[15]}}, ins[15:0], 2'b00};
  assign jumpTarget_s = {pcPlus4_s[31:28], ins[25:0], 2'b00};
  // The opcode field plays no part in target arithmetic.
  assign unusedOp_s   = ^ins[31:26];

  // Jump outranks a taken branch; everything else falls through to pc+4.
  always_comb begin
    npc = pcPlus4_s;
    if (Jump) begin
      npc = jumpTarget_s;
    end else if (Branch && zero) begin
      npc = pcPlus4_s + brOffset_s;
    end else begin
      npc = pcPlus4_s;
    end
  end

endmodule

// File: rtl/mips_ifu.sv
// Instruction fetch unit: PC, request/acknowledge fetch, instruction hold
// register for the decoder, next-PC update on accept and a retired counter.
module mips_ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [5:0]  op,
  output logic [31:0] pc,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] retired
);

  ifuState_t   state_r;
  logic        req_r;
  logic        valid_r;
  logic [31:0] pc_r;
  logic [31:0] ins_r;
  logic [31:0] retired_r;
  logic [31:0] npc_s;

  mips_npc uNpc (
    .pc     (pc_r),
    .ins    (ins_r),
    .Branch (Branch),
    .Jump   (Jump),
    .zero   (zero),
    .npc    (npc_s)
  );

  // Fetch/hold sequencer; handshake outputs are flops set alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      req_r     <= 1'b1;
      valid_r   <= 1'b0;
      pc_r      <= RESET_PC;
      ins_r     <= 32'd0;
      retired_r <= 32'd0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            ins_r   <= imem_rdata;
            state_r <= HOLD;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (ins_ready) begin
            pc_r      <= npc_s;
            retired_r <= retired_r + 32'd1;
            state_r   <= FETCH;
            req_r     <= 1'b1;
            valid_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_r;
  assign ins_valid = valid_r;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign ins       = ins_r;
  assign op        = ins_r[31:26];
  assign retired   = retired_r;

endmodule

// File: tb/tb_mips_ifu.sv
// Self-checking bench for mips_ifu: scoreboard of fetched words plus an
// independent next-PC reference model.
module tb_mips_ifu;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } expIns_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        Branch;
  logic        Jump;
  logic        zero;
  logic [31:0] retired;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] expPc;
  logic [31:0] expRetired;
  expIns_t     insQ[$];

  always #5 clk = ~clk;

  mips_ifu dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins        (ins),
    .op         (op),
    .pc         (pc),
    .Branch     (Branch),
    .Jump       (Jump),
    .zero       (zero),
    .retired    (retired)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] refNpc(input logic [31:0] curPc, input logic [31:0] word,
                                         input logic br, input logic jp, input logic zr);
    logic [31:0] seq;
    int          off;
    seq = curPc + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    else if (br && zr) return seq + 32'(off);
    else return seq;
  endfunction

  // One complete fetch/hold/accept transaction against the scoreboard.
  task automatic runIns(input logic [31:0] word, input int ackDelay, input int holdDelay,
                        input logic br, input logic jp, input logic zr, input bit presetWrap);
    expIns_t e;
    checkVal("fetch_req", b2w(imem_req), 32'd1);
    checkVal("fetch_addr", imem_addr, expPc);
    checkVal("fetch_valid", b2w(ins_valid), 32'd0);
    for (int i = 0; i < ackDelay; i++) begin
      imem_ack  = 1'b0;
      ins_ready = 1'b1;
      step();
      checkVal("stall_req", b2w(imem_req), 32'd1);
      checkVal("stall_addr", imem_addr, expPc);
      checkVal("stall_valid", b2w(ins_valid), 32'd0);
    end
    ins_ready  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    insQ.push_back('{pc: expPc, ins: word});
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    e = insQ.pop_front();
    checkVal("hold_valid", b2w(ins_valid), 32'd1);
    checkVal("hold_req", b2w(imem_req), 32'd0);
    checkVal("hold_ins", ins, e.ins);
    checkVal("hold_op", {26'd0, op}, {26'd0, e.ins[31:26]});
    checkVal("hold_pc", pc, e.pc);
    checkVal("hold_retired", retired, expRetired);
    for (int i = 0; i < holdDelay; i++) begin
      ins_ready  = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = ~word;
      step();
      checkVal("bp_ins", ins, e.ins);
      checkVal("bp_op", {26'd0, op}, {26'd0, e.ins[31:26]});
      checkVal("bp_pc", pc, e.pc);
      checkVal("bp_retired", retired, expRetired);
      checkVal("bp_valid", b2w(ins_valid), 32'd1);
    end
    imem_ack = 1'b0;
    if (presetWrap) begin
      force dut.retired_r = 32'hFFFF_FFFF;
      #1;
      release dut.retired_r;
      expRetired = 32'hFFFF_FFFF;
      checkVal("retired_preset", retired, expRetired);
    end
    Branch    = br;
    Jump      = jp;
    zero      = zr;
    ins_ready = 1'b1;
    expPc      = refNpc(e.pc, e.ins, br, jp, zr);
    expRetired = expRetired + 32'd1;
    step();
    ins_ready = 1'b0;
    Branch    = 1'b0;
    Jump      = 1'b0;
    zero      = 1'b0;
    checkVal("accept_pc", pc, expPc);
    checkVal("accept_retired", retired, expRetired);
    checkVal("accept_req", b2w(imem_req), 32'd1);
    checkVal("accept_valid", b2w(ins_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    ins_ready  = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    zero       = 1'b0;
    expPc      = DEFAULT_RESET_PC;
    expRetired = 32'd0;
    step();
    step();
    checkVal("rst_req", b2w(imem_req), 32'd1);
    checkVal("rst_valid", b2w(ins_valid), 32'd0);
    checkVal("rst_pc", pc, 32'h0000_3000);
    checkVal("rst_ins", ins, 32'd0);
    checkVal("rst_retired", retired, 32'd0);
    rst = 1'b0;

    runIns(32'h3401_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // ori
    checkVal("ori_pc", pc, 32'h0000_3004);
    checkVal("ori_retired", retired, 32'd1);
    for (int i = 0; i < 3; i++) runIns(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    runIns(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);   // beq taken
    checkVal("beq_taken", pc, 32'h0000_3010);
    runIns(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);   // beq not taken
    checkVal("beq_fall", pc, 32'h0000_3014);
    runIns(32'h0000_0000, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0);   // backpressure
    runIns(32'h0000_0000, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // memory stall
    runIns(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    runIns(32'h0800_0C40, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);   // j
    checkVal("j_pc", pc, 32'h0000_3100);
    runIns(32'h0800_0C40, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);   // j beats branch
    checkVal("j_prio", pc, 32'h0000_3100);
    runIns(32'h1000_FFFF, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);   // zero without Branch
    checkVal("nobranch", pc, 32'h0000_3104);
    runIns(32'h1000_0010, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);   // forward branch
    checkVal("fwd_branch", pc, 32'h0000_3148);
    runIns(32'h0800_0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);   // j to 0
    runIns(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);   // branch below 0
    checkVal("pc_underflow", pc, 32'hFFFF_FFFC);
    runIns(32'h0000_0000, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);   // pc and retired wrap
    checkVal("pc_wrap", pc, 32'd0);
    checkVal("retired_wrap", retired, 32'd0);

    // Reset while holding an instruction.
    checkVal("pre_hold_addr", imem_addr, expPc);
    imem_ack   = 1'b1;
    imem_rdata = 32'hAC22_0008;
    step();
    imem_ack = 1'b0;
    checkVal("pre_rst_valid", b2w(ins_valid), 32'd1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    expPc      = DEFAULT_RESET_PC;
    expRetired = 32'd0;
    checkVal("hrst_valid", b2w(ins_valid), 32'd0);
    checkVal("hrst_pc", pc, expPc);
    checkVal("hrst_retired", retired, expRetired);
    checkVal("hrst_req", b2w(imem_req), 32'd1);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    checkVal("stray_valid", b2w(ins_valid), 32'd0);
    checkVal("stray_pc", pc, expPc);
    checkVal("stray_retired", retired, expRetired);
    checkVal("stray_req", b2w(imem_req), 32'd1);

    // Reset during FETCH, then a late ack completes the fresh fetch.
    rst = 1'b1;
    step();
    rst = 1'b0;
    runIns(32'h8C22_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // lw
    checkVal("late_ack_pc", pc, 32'h0000_3004);
    checkVal("late_ack_retired", retired, 32'd1);
    runIns(32'hAC22_0008, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);   // sw

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
